clock_ratio_monitor: RTL and testbench
======================================

// Module: clock_ratio_monitor
// PURPOSE
//  Receive side of the CPU clock divider: samples a divided clock (clock_out or clock_microcode)
//  in the clock_in domain and measures its period in clock_in cycles. Checks that period
//  against the period implied by the programmed ratio. Reports lock, mismatch fault and
//  stopped-clock timeout to the debug/status path.
// PARAMETERS
//  DIV_SHIFT    1      expected period = (ratio+1) << DIV_SHIFT (1: microcode clock, 3: CPU clock)
//  TOLERANCE    1      max |measured - expected| in clock_in cycles still counted as a match
//  LOCK_COUNT   4      consecutive matching periods required to enter LOCKED (1..15)
//  PERIOD_MAX   16'hFFFF  saturation value of period counter; reaching it = timeout
// PORTS
//  clock_in         in   1   system clock; every flop is on its rising edge
//  reset_n          in   1   asynchronous, active-low reset
//  clock_probe      in   1   divided clock under test; treated as asynchronous
//  expected_ratio   in   8   ratio value programmed into the divider
//  restart          in   1   one-cycle pulse: abandon current state, return to IDLE
//  measured_period  out  16  last captured period, in clock_in cycles
//  period_valid     out  1   one-cycle pulse when measured_period updates
//  locked           out  1   high only in LOCKED
//  fault            out  1   sticky period-mismatch or timeout indication
//  timeout          out  1   sticky; set together with fault when the counter saturates
// BEHAVIOUR
//  Reset: every output is 0, state IDLE, counter 0, match_cnt 0, all sync flops 0.
//  Sync: clock_probe passes 2 flops, then a 3rd history flop. edge = sync2 & ~sync3.
//    edge is high 3 clock_in rising edges after a probe rise (+/-1 for metastability).
//  Counter: on edge, load 1. Otherwise increment, saturating at PERIOD_MAX.
//    With edges N cycles apart, counter = N in the cycle where the second edge is high.
//  expected = ({8'b0,expected_ratio} + 1) << DIV_SHIFT, computed in 16 bits.
//    Sampled live every cycle.
//  match = |counter - expected| <= TOLERANCE, computed with unsigned 16-bit difference.
//  States:
//   IDLE:    edge -> MEASURE. No capture; counter loads 1.
//   MEASURE: on edge: capture, period_valid=1.
//            match -> match_cnt+1; reaching LOCK_COUNT -> LOCKED.
//            mismatch -> match_cnt=0, stay in MEASURE.
//   LOCKED:  on edge: capture, period_valid=1. mismatch -> FAULT, set fault.
//   FAULT:   captures still happen on every edge; flags hold; leaves only via restart or reset.
//  Timeout: in any state except FAULT, counter == PERIOD_MAX -> FAULT, fault=1 and timeout=1
//    in the next cycle. measured_period is not updated by a timeout.
//  restart: from any state -> IDLE next cycle. Clears fault, timeout, match_cnt and counter.
//    Does not clear measured_period. restart beats a simultaneous edge or timeout; that edge
//    is discarded and the next edge counts as the first.
//  Registered outputs, 1-cycle latency: locked rises the cycle after the LOCK_COUNT-th matching
//    edge; fault rises the cycle after the mismatching edge.
//  Reset mid-operation: immediate return to reset values; no partial period survives.
//  Mismatch in MEASURE is never a fault, so ratio reprogramming before lock is tolerated.
// STRUCTURE
//  Package clock_pkg: state encoding (IDLE/MEASURE/LOCKED/FAULT, 2 bits); default parameter
//    constants; period width (16).
//  Sub-module probe_edge_sync: 3-flop synchronizer plus rising-edge pulse, with async reset.
//    Reused wherever divided clocks are sampled.
//  Top level holds the counter, expected/match arithmetic, FSM and output registers.
// TESTING
//  1. ratio=4, DIV_SHIFT=1, probe period 10 -> period_valid pulses carry 10; locked high after 5th edge (1 + 4 matches).
//  2. Locked at period 10, TOLERANCE=1; probe period becomes 12 -> fault=1, timeout=0, locked=0 cycle after edge.
//  3. PERIOD_MAX=255; probe stops high in LOCKED -> fault=1, timeout=1 at 255 cycles after last edge; measured_period stays 10.
//  4. restart asserted in same cycle as an edge in FAULT -> IDLE, flags 0; lock needs 5 further edges.
//  5. reset_n low for 1 cycle while LOCKED -> all outputs 0 asynchronously; relock after 5 edges.
//  6. Drive clock_probe from a real divider instance (ratio=2, DIV_SHIFT=1 and ratio=2, DIV_SHIFT=3) -> locked, periods 6 and 24.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: shared widths, default limits and FSM encoding for divided-clock monitors
package clock_pkg;
  localparam int PERIOD_W = 16;
  localparam int DEF_DIV_SHIFT = 1;
  localparam int DEF_TOLERANCE = 1;
  localparam int DEF_LOCK_COUNT = 4;
  localparam logic [PERIOD_W-1:0] DEF_PERIOD_MAX = 16'hFFFF;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;
  typedef logic [PERIOD_W-1:0] period_t;
endpackage

// File: rtl/probe_edge_sync.sv
// probe_edge_sync: two-flop synchronizer plus history flop, emitting a rising-edge pulse
module probe_edge_sync (
  input  logic clock_in,
  input  logic reset_n,
  input  logic async_in,
  output logic rise
);
  logic [2:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[1:0], async_in};
  always_ff @(posedge clock_in or negedge reset_n)
    if (!reset_n) sync_q <= '0;
    else sync_q <= sync_d;
  assign rise = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/clock_ratio_monitor.sv
// clock_ratio_monitor: measures a divided clock's period in clock_in cycles and reports lock/fault/timeout
module clock_ratio_monitor
  import clock_pkg::*;
#(
  parameter int DIV_SHIFT = DEF_DIV_SHIFT,
  parameter int TOLERANCE = DEF_TOLERANCE,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter logic [PERIOD_W-1:0] PERIOD_MAX = DEF_PERIOD_MAX
) (
  input  logic                clock_in,
  input  logic                reset_n,
  input  logic                clock_probe,
  input  logic [7:0]          expected_ratio,
  input  logic                restart,
  output logic [PERIOD_W-1:0] measured_period,
  output logic                period_valid,
  output logic                locked,
  output logic                fault,
  output logic                timeout
);
  localparam period_t TOL = PERIOD_W'(TOLERANCE);
  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  logic probe_rise;
  probe_edge_sync u_sync (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .async_in (clock_probe),
    .rise     (probe_rise)
  );
  logic [1:0] state_q, state_d;
  logic [3:0] match_cnt_q, match_cnt_d;
  period_t count_q, count_d, period_q, period_d, expected, diff;
  logic valid_q, valid_d, locked_q, locked_d, fault_q, fault_d, timeout_q, timeout_d;
  logic match, saturated;
  always_comb begin
    expected = ({8'b0, expected_ratio} + 16'd1) << DIV_SHIFT;
    diff = count_q >= expected ? count_q - expected : expected - count_q;
    match = diff <= TOL;
    saturated = count_q == PERIOD_MAX;
    count_d = restart ? '0 : probe_rise ? 16'd1 : saturated ? count_q : count_q + 16'd1;
    state_d = state_q;
    match_cnt_d = match_cnt_q;
    fault_d = fault_q;
    timeout_d = timeout_q;
    period_d = period_q;
    valid_d = 1'b0;
    // restart outranks timeout, which outranks a coincident edge
    if (restart) begin
      state_d = ST_IDLE;
      match_cnt_d = '0;
      fault_d = 1'b0;
      timeout_d = 1'b0;
    end else if (saturated && state_q != ST_FAULT) begin
      state_d = ST_FAULT;
      fault_d = 1'b1;
      timeout_d = 1'b1;
    end else if (probe_rise) begin
      period_d = state_q != ST_IDLE ? count_q : period_q;
      valid_d = state_q != ST_IDLE;
      case (state_q)
        ST_IDLE: state_d = ST_MEASURE;
        ST_MEASURE: begin
          match_cnt_d = match ? match_cnt_q + 4'd1 : '0;
          state_d = match && match_cnt_q + 4'd1 >= LOCK_N ? ST_LOCKED : ST_MEASURE;
        end
        ST_LOCKED: begin
          state_d = match ? ST_LOCKED : ST_FAULT;
          fault_d = !match;
        end
        default: state_d = ST_FAULT;
      endcase
    end
    locked_d = state_d == ST_LOCKED;
  end
  always_ff @(posedge clock_in or negedge reset_n)
    if (!reset_n) begin
      state_q <= ST_IDLE;
      match_cnt_q <= '0;
      count_q <= '0;
      period_q <= '0;
      valid_q <= 1'b0;
      locked_q <= 1'b0;
      fault_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      match_cnt_q <= match_cnt_d;
      count_q <= count_d;
      period_q <= period_d;
      valid_q <= valid_d;
      locked_q <= locked_d;
      fault_q <= fault_d;
      timeout_q <= timeout_d;
    end
  assign measured_period = period_q;
  assign period_valid = valid_q;
  assign locked = locked_q;
  assign fault = fault_q;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_clock_ratio_monitor.sv
// tb_clock_ratio_monitor: directed, table-driven and randomized checks against a period-arithmetic model
module tb_clock_ratio_monitor;
  localparam int PMAX = 255;
  typedef struct {int ratio; int period; int reps; int mp; bit lk; bit ft;} vec_t;
  logic clock_in = 0, reset_n = 1, clock_probe = 0, restart = 0;
  logic [7:0] expected_ratio = 8'd4;
  logic [15:0] measured_period, mp3;
  logic period_valid, locked, fault, timeout, pv3, lk3, ft3, to3, probe3;
  int div_cnt;
  int checks = 0, errors = 0;
  int p = 0, anchor = 0, m_state = 0, m_nm = 0, m_mp = 0;
  bit m_pv = 0, m_lk = 0, m_ft = 0, m_to = 0;
  bit hist[$];

  clock_ratio_monitor #(.DIV_SHIFT(1), .TOLERANCE(1), .LOCK_COUNT(4), .PERIOD_MAX(16'(PMAX))) dut (
    .clock_in(clock_in), .reset_n(reset_n), .clock_probe(clock_probe), .expected_ratio(expected_ratio),
    .restart(restart), .measured_period(measured_period), .period_valid(period_valid),
    .locked(locked), .fault(fault), .timeout(timeout));

  clock_ratio_monitor #(.DIV_SHIFT(3)) dut3 (
    .clock_in(clock_in), .reset_n(reset_n), .clock_probe(probe3), .expected_ratio(8'd2),
    .restart(1'b0), .measured_period(mp3), .period_valid(pv3),
    .locked(lk3), .fault(ft3), .timeout(to3));

  always #5 clock_in = ~clock_in;

  // divide-by-24 source for the DIV_SHIFT=3 instance: toggles every 12 cycles
  always @(posedge clock_in or negedge reset_n)
    if (!reset_n) begin
      div_cnt <= 0;
      probe3 <= 0;
    end else if (div_cnt == 11) begin
      div_cnt <= 0;
      probe3 <= ~probe3;
    end else div_cnt <= div_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    anchor = p;
    m_state = 0; m_nm = 0; m_mp = 0;
    m_pv = 0; m_lk = 0; m_ft = 0; m_to = 0;
    hist = '{0, 0, 0, 0};
  endtask

  // counter value is the clipped age since the last anchor; edges appear two pushes after a rise
  task automatic model_step(input bit pr, input bit rs);
    int c, ex, d;
    bit e, m;
    hist.push_back(pr);
    if (hist.size() > 8) void'(hist.pop_front());
    e = hist[hist.size()-3] && !hist[hist.size()-4];
    p++;
    c = p - 1 - anchor;
    if (c > PMAX) c = PMAX;
    ex = ((int'(expected_ratio) + 1) * 2) & 16'hFFFF;
    d = c > ex ? c - ex : ex - c;
    m = d <= 1;
    m_pv = 0;
    if (rs) begin
      m_state = 0; m_nm = 0; m_ft = 0; m_to = 0;
      anchor = p;
    end else begin
      if (e) anchor = p - 1;
      if (m_state != 3 && c == PMAX) begin
        m_state = 3; m_ft = 1; m_to = 1;
      end else if (e) begin
        if (m_state != 0) begin m_mp = c; m_pv = 1; end
        if (m_state == 0) m_state = 1;
        else if (m_state == 1) begin
          m_nm = m ? m_nm + 1 : 0;
          if (m_nm == 4) m_state = 2;
        end else if (m_state == 2 && !m) begin
          m_state = 3; m_ft = 1;
        end
      end
    end
    m_lk = m_state == 2;
  endtask

  task automatic cyc(input bit pr, input bit rs);
    clock_probe = pr;
    restart = rs;
    model_step(pr, rs);
    @(posedge clock_in);
    @(negedge clock_in);
    chk("measured_period", measured_period, m_mp);
    chk("period_valid", period_valid, m_pv);
    chk("locked", locked, m_lk);
    chk("fault", fault, m_ft);
    chk("timeout", timeout, m_to);
  endtask

  task automatic run_period(input int per, input int n, input bit rs_edge);
    bit done, r;
    done = 0;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < per; k++) begin
        r = rs_edge && !done && hist[hist.size()-2] && !hist[hist.size()-3];
        if (r) done = 1;
        cyc(k < (per + 1) / 2, r);
      end
  endtask

  task automatic do_reset();
    reset_n = 0;
    #1;
    model_reset();
    chk("rst_measured_period", measured_period, 0);
    chk("rst_period_valid", period_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_fault", fault, 0);
    chk("rst_timeout", timeout, 0);
    @(posedge clock_in);
    @(negedge clock_in);
    reset_n = 1;
    model_reset();
  endtask

  initial begin
    vec_t tbl[$];
    int n, per, ex;
    tbl = '{'{4, 10, 6, 10, 1, 0}, '{2, 6, 6, 6, 1, 0}, '{4, 11, 6, 11, 1, 0}, '{4, 9, 6, 9, 1, 0},
            '{4, 12, 6, 12, 0, 0}, '{9, 20, 6, 20, 1, 0}, '{0, 2, 6, 2, 1, 0}, '{3, 7, 6, 7, 1, 0},
            '{4, 10, 3, 10, 0, 0}};
    @(negedge clock_in);
    do_reset();
    run_period(10, 4, 0);
    chk("t1_not_yet_locked", locked, 0);
    chk("t1_period", measured_period, 10);
    run_period(10, 1, 0);
    chk("t1_locked", locked, 1);
    run_period(12, 2, 0);
    chk("t2_fault", fault, 1);
    chk("t2_timeout", timeout, 0);
    chk("t2_locked", locked, 0);
    chk("t2_period", measured_period, 12);
    cyc(0, 1);
    run_period(10, 5, 0);
    chk("t3_relocked", locked, 1);
    n = 0;
    do begin
      cyc(1, 0);
      n++;
    end while (!fault && n < 400);
    chk("t3_timeout_cycles", n, 258);
    for (int i = 0; i < 5; i++) cyc(1, 0);
    chk("t3_fault", fault, 1);
    chk("t3_timeout", timeout, 1);
    chk("t3_period_kept", measured_period, 10);
    for (int i = 0; i < 5; i++) cyc(0, 0);
    run_period(10, 1, 1);
    chk("t4_fault_cleared", fault, 0);
    chk("t4_timeout_cleared", timeout, 0);
    chk("t4_period_kept", measured_period, 10);
    run_period(10, 4, 0);
    chk("t4_not_yet_locked", locked, 0);
    run_period(10, 1, 0);
    chk("t4_locked", locked, 1);
    do_reset();
    run_period(10, 4, 0);
    chk("t5_not_yet_locked", locked, 0);
    run_period(10, 1, 0);
    chk("t5_locked", locked, 1);
    foreach (tbl[i]) begin
      expected_ratio = 8'(tbl[i].ratio);
      cyc(0, 1);
      cyc(0, 0);
      run_period(tbl[i].period, tbl[i].reps, 0);
      chk($sformatf("tbl%0d_period", i), measured_period, tbl[i].mp);
      chk($sformatf("tbl%0d_locked", i), locked, tbl[i].lk);
      chk($sformatf("tbl%0d_fault", i), fault, tbl[i].ft);
    end
    for (int b = 0; b < 40; b++) begin
      expected_ratio = 8'($urandom_range(1, 6));
      ex = (int'(expected_ratio) + 1) * 2;
      for (int i = 0; i < 8; i++) begin
        per = ex + int'($urandom_range(0, 4)) - 2;
        run_period(per, 1, $urandom_range(0, 9) == 0);
      end
    end
    chk("div3_period", mp3, 24);
    chk("div3_locked", lk3, 1);
    chk("div3_fault", ft3, 0);
    chk("div3_timeout", to3, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
